// File: rtl/if_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_if
//   Instruction-memory bus between the fetch stage and instruction memory.
//   One request is accepted per req/gnt handshake. The read data comes back on
//   a later cycle, qualified by rvalid. At most one fetch is outstanding.
//
//   Signals
//     req    fetch side -> memory   fetch request
//     addr   fetch side -> memory   fetch address (32 bit)
//     gnt    memory -> fetch side   request accepted this cycle
//     rvalid memory -> fetch side   read data valid
//     rdata  memory -> fetch side   instruction word (32 bit)
//
//   Modports
//     master  fetch stage
//     slave   instruction memory
// -----------------------------------------------------------------------------
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage together with the IF/ID pipeline register.
//   - Owns the PC.
//   - Fetches through a req/gnt + rvalid memory bus, with one fetch in flight.
//   - Honours the decode hazard freeze.
//   - Honours a branch redirect from EXE, which flushes IF/ID.
//   Decode receives the fetch address + PC_STEP and the instruction word.
//   A bubble is an all-zero instruction with id_valid = 0.
//
//   Parameters
//     RESET_PC  PC loaded on reset
//     PC_STEP   byte increment between sequential fetches
//
//   Ports
//     clk             clock, all state on the rising edge
//     rst             asynchronous, active-low reset
//     freeze          hazard stall: hold PC and IF/ID
//     branch_taken    redirect: flush IF/ID, discard any in-flight fetch
//     branch_addr     redirect target
//     imem            instruction-memory bus (master side)
//     id_pc           registered fetch address + PC_STEP
//     id_instruction  registered instruction (0 for a bubble)
//     id_valid        IF/ID holds a real instruction
//
//   Optional build macro IF_PERF_CNT_EN adds two counters, both reset to 0 and wrapping:
//     perf_fetched    instructions loaded into IF/ID
//     perf_dropped    responses discarded after a redirect
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_addr,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            id_pc,
    output logic [31:0]            id_instruction,
    output logic                   id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_dropped
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    // REQ : request presented, waiting for gnt
    // WAIT: granted, waiting for rvalid
    // DROP: granted, but the response is to be thrown away after a redirect
    // HOLD: response captured while decode was frozen
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] buf_reg;

    logic        deliver;       // an instruction moves into IF/ID this cycle
    logic [31:0] deliver_data;
    logic        capture;       // park rdata in the buffer while frozen
    logic        discard;       // a fetched word is thrown away this cycle

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_REQ;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        deliver      = 1'b0;
        deliver_data = imem.rdata;
        capture      = 1'b0;
        discard      = 1'b0;
        case (state_reg)
            ST_REQ: begin
                // An ungranted request may retarget freely.
                // A granted one must have its data drained in DROP.
                if (branch_taken) begin
                    pc_next = branch_addr;
                    if (imem.gnt) begin
                        state_next = ST_DROP;
                    end
                end else if (imem.gnt) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (branch_taken) begin
                    pc_next = branch_addr;
                    if (imem.rvalid) begin
                        discard    = 1'b1;
                        state_next = ST_REQ;
                    end else begin
                        state_next = ST_DROP;
                    end
                end else if (imem.rvalid) begin
                    if (freeze) begin
                        capture    = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        deliver    = 1'b1;
                        pc_next    = pc_reg + STEP;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_DROP: begin
                if (branch_taken) begin
                    pc_next = branch_addr;
                end
                if (imem.rvalid) begin
                    discard    = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    discard    = 1'b1;
                    pc_next    = branch_addr;
                    state_next = ST_REQ;
                end else if (!freeze) begin
                    deliver      = 1'b1;
                    deliver_data = buf_reg;
                    pc_next      = pc_reg + STEP;
                    state_next   = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        imem.req  = (state_reg == ST_REQ);
        imem.addr = pc_reg;
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_reg <= 32'h0;
        end else if (capture) begin
            buf_reg <= imem.rdata;
        end
    end

    // IF/ID register. The priority order is:
    //   flush > freeze hold > load > bubble
    // On a bubble id_pc keeps its value; only the instruction and valid clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc          <= 32'h0;
            id_instruction <= 32'h0;
            id_valid       <= 1'b0;
        end else if (branch_taken) begin
            id_pc          <= 32'h0;
            id_instruction <= 32'h0;
            id_valid       <= 1'b0;
        end else if (!freeze) begin
            if (deliver) begin
                id_pc          <= pc_reg + STEP;
                id_instruction <= deliver_data;
                id_valid       <= 1'b1;
            end else begin
                id_instruction <= 32'h0;
                id_valid       <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= 32'h0;
            perf_dropped <= 32'h0;
        end else begin
            if (deliver) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (discard) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
        end
    end
`else
    // discard only feeds the optional counters
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] STEP     = 32'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    if_fetch_stage_if imem_bus ();

    if_fetch_stage #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem           (imem_bus),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_valid       (id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A01005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: the fetch unit described as "a fetch in flight (maybe doomed)"
    // plus "a parked word", not as a state machine
    logic [31:0] m_pc;
    bit          m_wait;       // a granted fetch has not returned yet
    bit          m_kill;       // that fetch was redirected away and must be dropped
    bit          m_held;       // a word is parked behind a freeze
    logic [31:0] m_held_data;
    logic [31:0] e_id_pc, e_id_instr;
    bit          e_id_valid;
    logic [31:0] e_fetched, e_dropped;

    // Memory environment: one outstanding read, data returned on a later cycle
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;

    // Stimulus knobs (percent)
    int          p_gnt, p_rv, p_frz, p_br;
    bit          br_use_fixed;
    logic [31:0] br_fixed;

    function automatic bit roll(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_wait = 0; m_kill = 0; m_held = 0; m_held_data = 0;
        e_id_pc = 0; e_id_instr = 0; e_id_valid = 0; e_fetched = 0; e_dropped = 0;
    endtask

    task automatic drive();
        freeze       = roll(p_frz);
        branch_taken = roll(p_br);
        if (br_use_fixed) branch_addr = br_fixed;
        else if (roll(20)) branch_addr = 32'hFFFF_FFFC;
        else branch_addr = $urandom() & 32'hFFFF_FFFC;
        imem_bus.gnt    = !mem_busy && roll(p_gnt);
        imem_bus.rvalid = mem_busy && roll(p_rv);
        imem_bus.rdata  = imem_bus.rvalid ? mem_word(mem_addr) : $urandom();
    endtask

    task automatic model_step();
        bit          req, resp, avail;
        logic [31:0] data, pc_before;
        pc_before = m_pc;
        req   = !m_wait && !m_held;
        resp  = m_wait && imem_bus.rvalid;
        avail = m_held || (resp && !m_kill);
        data  = m_held ? m_held_data : imem_bus.rdata;
        if (resp && m_kill) e_dropped++;
        if (branch_taken) begin
            if (avail) e_dropped++;
            m_held = 0;
            e_id_pc = 0; e_id_instr = 0; e_id_valid = 0;
            m_pc = branch_addr;
            if (resp) begin m_wait = 0; m_kill = 0; end
            else if (m_wait) m_kill = 1;
            if (req && imem_bus.gnt) begin m_wait = 1; m_kill = 1; end
        end else begin
            if (resp) begin m_wait = 0; m_kill = 0; end
            if (freeze) begin
                if (avail) begin m_held = 1; m_held_data = data; end
            end else if (avail) begin
                e_id_pc = m_pc + STEP; e_id_instr = data; e_id_valid = 1;
                m_pc = m_pc + STEP; m_held = 0; e_fetched++;
                $display("fetch id_pc=%h instr=%h", e_id_pc, e_id_instr);
            end else begin
                e_id_instr = 0; e_id_valid = 0;
            end
            if (req && imem_bus.gnt) m_wait = 1;
        end
        if (imem_bus.rvalid) mem_busy = 0;
        if (req && imem_bus.gnt) begin mem_busy = 1; mem_addr = pc_before; end
    endtask

    task automatic compare();
        check("imem_req",  {31'b0, imem_bus.req}, {31'b0, !m_wait && !m_held});
        check("imem_addr", imem_bus.addr, m_pc);
        check("id_pc",     id_pc, e_id_pc);
        check("id_instr",  id_instruction, e_id_instr);
        check("id_valid",  {31'b0, id_valid}, {31'b0, e_id_valid});
`ifdef IF_PERF_CNT_EN
        check("perf_fetched", perf_fetched, e_fetched);
        check("perf_dropped", perf_dropped, e_dropped);
`endif
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // Called at a falling edge; the memory keeps any outstanding read across reset
    task automatic do_reset();
        rst = 1'b0;
        freeze = 0; branch_taken = 0; imem_bus.gnt = 0; imem_bus.rvalid = 0;
        model_reset();
        #1 compare();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        compare();
    endtask

    task automatic knobs(input int g, input int r, input int f, input int b, input logic [31:0] ba);
        p_gnt = g; p_rv = r; p_frz = f; p_br = b; br_use_fixed = 1; br_fixed = ba;
    endtask

    initial begin
        imem_bus.gnt = 0; imem_bus.rvalid = 0; imem_bus.rdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr",  imem_bus.addr, RESET_PC);
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        rst = 1'b1;
        compare();

        // Back-to-back handshakes: fetch address 0, then 4
        knobs(100, 100, 0, 0, 0);
        cycle();                                              // c1: grant address 0
        cycle();                                              // c2: data returns
        check("t1_instr", id_instruction, 32'hE3A01005);
        check("t1_pc",    id_pc, 32'd4);
        check("t1_valid", {31'b0, id_valid}, 32'h1);
        cycle();                                              // c3: bubble
        check("t2_bubble", {31'b0, id_valid}, 32'h0);
        cycle();                                              // c4: second word
        check("t2_pc", id_pc, 32'd8);
        cycle();                                              // c5: grant address 8

        // Freeze arrives with the response for address 8
        knobs(100, 100, 100, 0, 0);
        cycle();                                              // c6: HOLD
        check("t3_req",   {31'b0, imem_bus.req}, 32'h0);
        check("t3_id_pc", id_pc, 32'd8);
        knobs(100, 100, 0, 0, 0);
        cycle();                                              // c7: released
        check("t3_rel_pc",   id_pc, 32'd12);
        check("t3_rel_addr", imem_bus.addr, 32'd12);

        // Redirect while waiting for data
        cycle();                                              // c8: grant address 12
        knobs(100, 0, 0, 100, 32'h100);
        cycle();                                              // c9: redirect -> DROP
        check("t4_valid", {31'b0, id_valid}, 32'h0);
        check("t4_req",   {31'b0, imem_bus.req}, 32'h0);
        knobs(100, 100, 0, 0, 0);
        cycle();                                              // c10: stale data drained
        check("t4_addr", imem_bus.addr, 32'h100);
`ifdef IF_PERF_CNT_EN
        check("t4_dropped", perf_dropped, 32'd1);
`endif

        // Redirect while HOLD, with freeze still asserted
        cycle();                                              // c11: grant 0x100
        knobs(100, 100, 100, 0, 0);
        cycle();                                              // c12: HOLD
        knobs(100, 0, 100, 100, 32'h200);
        cycle();                                              // c13: flush
        check("t5_id_pc", id_pc, 32'h0);
        check("t5_instr", id_instruction, 32'h0);
        check("t5_addr",  imem_bus.addr, 32'h200);

        // PC wrap-around
        knobs(0, 0, 0, 100, 32'hFFFF_FFFC);
        cycle();                                              // c14: retarget while ungranted
        check("wrap_addr", imem_bus.addr, 32'hFFFF_FFFC);
        knobs(100, 100, 0, 0, 0);
        cycle();                                              // c15: grant
        cycle();                                              // c16: data returns
        check("wrap_id_pc", id_pc, 32'h0);
        check("wrap_valid", {31'b0, id_valid}, 32'h1);
        check("wrap_addr2", imem_bus.addr, 32'h0);

        // Reset mid-WAIT, then a stale rvalid after release
        knobs(100, 100, 0, 0, 0);
        cycle();                                              // c17: grant address 0
        do_reset();
        cycle();                                              // stale rvalid pulse
        check("t6_addr",  imem_bus.addr, RESET_PC);
        check("t6_instr", id_instruction, 32'h0);
        check("t6_valid", {31'b0, id_valid}, 32'h0);
        check("t6_req",   {31'b0, imem_bus.req}, 32'h1);

        // Randomized traffic against the model
        p_gnt = 70; p_rv = 50; p_frz = 25; p_br = 8; br_use_fixed = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) do_reset();
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
